frame_buffer_ctrl: RTL and testbench
====================================

# frame_buffer_ctrl

Double-buffer controller on the AXI clock domain that owns the framebuffer base address fed to the frame reader's `base_addr` input. Software programs a back-buffer address and requests a swap over an AXI4-Lite slave; the swap takes effect only on the synchronised end-of-frame pulse, so the frame reader never switches buffers mid-frame. It also counts frames and raises a swap-done interrupt.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: AXI4-Lite data width; only 32 supported.
- `C_S_AXI_ADDR_WIDTH`, 4: AXI4-Lite byte address width; bits [3:2] select the register.
- `RESET_BASE_ADDR`, 32'h00108078: reset value of front and back addresses.
- `S_AXI_ACLK`  in  1  sole clock; same clock as the frame reader's AXI master.
- `S_AXI_ARESETN`  in  1  asynchronous active-low reset.
- `S_AXI_AWADDR`/`AWPROT`/`AWVALID`/`AWREADY`, `S_AXI_WDATA`/`WSTRB`/`WVALID`/`WREADY`, `S_AXI_BRESP`/`BVALID`/`BREADY`, `S_AXI_ARADDR`/`ARPROT`/`ARVALID`/`ARREADY`, `S_AXI_RDATA`/`RRESP`/`RVALID`/`RREADY`: standard AXI4-Lite slave, widths per parameters; `*PROT` ignored.
- `end_of_frame`  in  1  one-cycle pulse from the vblank edge synchroniser.
- `base_addr`  out  32  current front-buffer address to the frame reader.
- `swap_irq`  out  1  level interrupt = IRQ flag AND IRQ_EN.

## Operation
- Register map (byte offset):
  - 0x0 CTRL: bit0 SWAP_REQ (write 1 sets pending, write 0 no effect; reads pending state), bit1 IRQ_EN (RW). Other bits read 0.
  - 0x4 BACK_ADDR: RW, per-byte WSTRB honoured; bits[1:0] forced 0 (word aligned).
  - 0x8 FRONT_ADDR: RO, equals `base_addr`; writes ignored.
  - 0xC STATUS: bit0 IRQ flag (write 1 clears), bits[31:16] frame counter (RO).
- CTRL/STATUS writes act only when WSTRB[0] is set.
- On `end_of_frame`:
  - frame counter increments, wrapping 0xFFFF -> 0x0000.
  - if pending: `base_addr` <= BACK_ADDR, BACK_ADDR <= old `base_addr` (true swap), pending cleared, IRQ flag set.
  - if not pending: addresses unchanged, IRQ flag unchanged.
- BACK_ADDR writes while pending is set are ignored (software must wait for swap).
- Simultaneous events, same cycle:
  - SWAP_REQ write with `end_of_frame` and no prior pending: no swap this frame; pending becomes 1 and swap occurs at the next `end_of_frame`.
  - IRQ W1C with a swap setting the flag: set wins.
  - BACK_ADDR write with swap: write ignored (pending).
- Reset mid-operation: all state returns to reset values immediately; pending swap discarded.

## Timing
- Reset values: `base_addr` = BACK_ADDR = RESET_BASE_ADDR; AWREADY, WREADY, BVALID, ARREADY, RVALID, `swap_irq` = 0; BRESP = RRESP = 2'b00; RDATA = 0; pending, IRQ_EN, IRQ flag, counter = 0.
- Write channel: when AWVALID && WVALID && !BVALID && !AWREADY, AWREADY and WREADY pulse high together for one cycle and the register updates on that edge. BVALID rises the next cycle and holds until BREADY. AW/W are never accepted individually.
- Read channel: when ARVALID && !RVALID && !ARREADY, ARREADY pulses for one cycle. RVALID with RDATA rises the next cycle and holds stable until RREADY.
- A read accepted in the same cycle as a write returns the pre-write value.
- BRESP and RRESP are always OKAY.
- `base_addr` and the IRQ flag change on the clock edge sampling `end_of_frame` high, visible the next cycle. `swap_irq` is registered and follows the flag/IRQ_EN one cycle later.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then read 0x8 and 0x4 -> both 0x00108078; STATUS 0x00000000; `swap_irq` 0.
- Write BACK_ADDR 0x2000_0000, CTRL 0x3, then pulse `end_of_frame` -> next cycle `base_addr` = 0x2000_0000, BACK_ADDR reads 0x00108078, CTRL reads 0x2, STATUS bit0 = 1, `swap_irq` = 1 one cycle later. Write STATUS 0x1 -> `swap_irq` drops.
- SWAP_REQ write in the same cycle as `end_of_frame` -> `base_addr` unchanged; swap occurs at the following `end_of_frame`.
- With pending set, write BACK_ADDR 0x3000_0000 -> ignored; readback is the prior value. Write with WSTRB = 4'b0001 when not pending -> only byte 0 changes, with bits[1:0] = 0.
- 65536 `end_of_frame` pulses -> counter wraps to 0x0000. Assert reset with a swap pending -> after reset no swap occurs on the next `end_of_frame`.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable, and no second transaction is accepted.

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered framebuffer base-address controller with an AXI4-Lite register slave.
// A requested swap is applied only on the end-of-frame pulse, so the reader never tears mid-frame.
module frame_buffer_ctrl #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] RESET_BASE_ADDR    = 32'h0010_8078
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              end_of_frame,
    output logic [31:0]                       base_addr,
    output logic                              swap_irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_BACK   = 2'd1;
    localparam logic [1:0] REG_FRONT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] base_q, base_d;
    logic [31:0] back_q, back_d;
    logic        pending_q, pending_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_flag_q, irq_flag_d;
    logic [15:0] cnt_q, cnt_d;
    logic        swap_irq_q, swap_irq_d;

    logic        wr_en_s, rd_en_s, swap_s;
    logic        ctrl_wr_s, back_wr_s, stat_wr_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // Byte-lane merge for BACK_ADDR writes; the address stays word aligned.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        res[1:0] = 2'b00;
        return res;
    endfunction

    // Handshakes, register read mux and frame/swap next-state logic.
    always_comb begin
        wr_en_s   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
        rd_en_s   = arready_q & S_AXI_ARVALID;
        swap_s    = end_of_frame & pending_q;
        ctrl_wr_s = wr_en_s & (S_AXI_AWADDR[3:2] == REG_CTRL)   & S_AXI_WSTRB[0];
        back_wr_s = wr_en_s & (S_AXI_AWADDR[3:2] == REG_BACK);
        stat_wr_s = wr_en_s & (S_AXI_AWADDR[3:2] == REG_STATUS) & S_AXI_WSTRB[0];

        case (S_AXI_ARADDR[3:2])
            REG_CTRL:   rd_mux_s = {30'd0, irq_en_q, pending_q};
            REG_BACK:   rd_mux_s = back_q;
            REG_FRONT:  rd_mux_s = base_q;
            REG_STATUS: rd_mux_s = {cnt_q, 15'd0, irq_flag_q};
            default:    rd_mux_s = 32'd0;
        endcase

        if (S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q) begin
            awready_d = 1'b1;
        end else begin
            awready_d = 1'b0;
        end

        if (wr_en_s) begin
            bvalid_d = 1'b1;
        end else if (S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        if (S_AXI_ARVALID && !rvalid_q && !arready_q) begin
            arready_d = 1'b1;
        end else begin
            arready_d = 1'b0;
        end

        if (rd_en_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux_s;
        end else if (S_AXI_RREADY) begin
            rvalid_d = 1'b0;
            rdata_d  = rdata_q;
        end else begin
            rvalid_d = rvalid_q;
            rdata_d  = rdata_q;
        end

        if (end_of_frame) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // A request landing on the swap frame itself is held for the next frame.
        if (ctrl_wr_s && S_AXI_WDATA[0]) begin
            pending_d = 1'b1;
        end else if (swap_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (ctrl_wr_s) begin
            irq_en_d = S_AXI_WDATA[1];
        end else begin
            irq_en_d = irq_en_q;
        end

        if (swap_s) begin
            irq_flag_d = 1'b1;
        end else if (stat_wr_s && S_AXI_WDATA[0]) begin
            irq_flag_d = 1'b0;
        end else begin
            irq_flag_d = irq_flag_q;
        end

        if (swap_s) begin
            base_d = back_q;
            back_d = base_q;
        end else if (back_wr_s && !pending_q) begin
            base_d = base_q;
            back_d = merge_word(back_q, S_AXI_WDATA[31:0], S_AXI_WSTRB[3:0]);
        end else begin
            base_d = base_q;
            back_d = back_q;
        end

        swap_irq_d = irq_flag_q & irq_en_q;
    end

    // State registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            base_q     <= RESET_BASE_ADDR;
            back_q     <= RESET_BASE_ADDR;
            pending_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_flag_q <= 1'b0;
            cnt_q      <= 16'd0;
            swap_irq_q <= 1'b0;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            base_q     <= base_d;
            back_q     <= back_d;
            pending_q  <= pending_d;
            irq_en_q   <= irq_en_d;
            irq_flag_q <= irq_flag_d;
            cnt_q      <= cnt_d;
            swap_irq_q <= swap_irq_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign base_addr     = base_q;
    assign swap_irq      = swap_irq_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: directed vector table, hand-built corner sequences and
// randomized register/frame traffic checked against a behavioural register model.
module tb_frame_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, base_addr;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        eof, swap_irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frame_buffer_ctrl dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .end_of_frame(eof), .base_addr(base_addr), .swap_irq(swap_irq)
    );

    // Register model: the programmer-visible state described by the register map.
    logic [31:0] m_base, m_back;
    logic        m_pend, m_en, m_flag;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_base = 32'h0010_8078; m_back = 32'h0010_8078;
        m_pend = 1'b0; m_en = 1'b0; m_flag = 1'b0; m_cnt = 16'd0;
    endtask

    // One clock edge worth of effects: an optional register write and an optional frame end.
    task automatic model_step(input bit wr, input logic [3:0] a, input logic [31:0] d,
                              input logic [3:0] s, input bit frame_end);
        logic [31:0] old_base, old_back;
        bit was_pending, swapped;
        old_base = m_base; old_back = m_back; was_pending = m_pend;
        swapped = frame_end && was_pending;
        if (frame_end) m_cnt = m_cnt + 16'd1;
        if (swapped) begin
            m_base = old_back; m_back = old_base; m_pend = 1'b0; m_flag = 1'b1;
        end
        if (wr) begin
            case (a[3:2])
                2'd0: if (s[0]) begin
                    if (d[0]) m_pend = 1'b1;
                    m_en = d[1];
                end
                2'd1: if (!was_pending) begin
                    for (int b = 0; b < 4; b++) if (s[b]) m_back[8*b +: 8] = d[8*b +: 8];
                    m_back[1:0] = 2'b00;
                end
                2'd3: if (s[0] && d[0] && !swapped) m_flag = 1'b0;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {30'd0, m_en, m_pend};
            2'd1:    return m_back;
            2'd2:    return m_base;
            default: return {m_cnt, 15'd0, m_flag};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // AXI write; optional end_of_frame on the handshake edge; optional BREADY stall cycles.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit eof_hs, input int hold);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = (hold == 0);
        @(posedge clk); #1;
        while (!awready && n < 16) begin @(posedge clk); #1; n++; end
        chk("awready_seen", awready, 1'b1);
        if (!awready) begin awvalid = 1'b0; wvalid = 1'b0; return; end
        chk("wready_with_awready", wready, 1'b1);
        if (eof_hs) eof = 1'b1;
        @(posedge clk); #1;
        eof = 1'b0;
        model_step(1'b1, a, d, s, eof_hs);
        chk("bvalid_rise", bvalid, 1'b1);
        chk("bresp", bresp, 2'b00);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", bvalid, 1'b1);
            chk("no_second_aw", awready, 1'b0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        if (hold > 0) chk("bvalid_drop", bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [3:0] a, input int hold, output logic [31:0] d);
        int n = 0;
        logic [31:0] first;
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        @(posedge clk); #1;
        while (!arready && n < 16) begin @(posedge clk); #1; n++; end
        chk("arready_seen", arready, 1'b1);
        if (!arready) begin arvalid = 1'b0; d = 32'hDEAD_BEEF; return; end
        @(posedge clk); #1;
        chk("rvalid_rise", rvalid, 1'b1);
        chk("rresp", rresp, 2'b00);
        first = rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("rvalid_hold", rvalid, 1'b1);
            chk("rdata_stable", rdata, first);
            chk("no_second_ar", arready, 1'b0);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        if (hold > 0) chk("rvalid_drop", rvalid, 1'b0);
        d = first;
    endtask

    task automatic pulse_eof();
        eof = 1'b1;
        @(posedge clk); #1;
        eof = 1'b0;
        model_step(1'b0, 4'h0, 32'd0, 4'h0, 1'b1);
        chk("base_after_eof", base_addr, m_base);
    endtask

    localparam int OP_RD = 0, OP_WR = 1, OP_EOF = 2, OP_BASE = 3, OP_IRQ = 4, OP_IRQNOW = 5;
    typedef struct {
        int          op;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input int op, input logic [3:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.strb = s; v.exp = e;
        tbl.push_back(v);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [15:0] c0;
        rst_n = 1'b0; eof = 1'b0;
        awaddr = 4'h0; araddr = 4'h0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'd0; wstrb = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_base", base_addr, 32'h0010_8078);
        chk("rst_awready", awready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", swap_irq, 1'b0);

        // Directed register-map walk with fixed expectations.
        add(OP_RD,     4'h8, 32'd0,          4'h0, 32'h0010_8078);
        add(OP_RD,     4'h4, 32'd0,          4'h0, 32'h0010_8078);
        add(OP_RD,     4'hC, 32'd0,          4'h0, 32'h0000_0000);
        add(OP_IRQNOW, 4'h0, 32'd0,          4'h0, 32'd0);
        add(OP_WR,     4'h4, 32'h2000_0000,  4'hF, 32'd0);
        add(OP_WR,     4'h0, 32'h0000_0003,  4'h1, 32'd0);
        add(OP_RD,     4'h0, 32'd0,          4'h0, 32'h0000_0003);
        add(OP_WR,     4'h4, 32'h3000_0000,  4'hF, 32'd0);
        add(OP_RD,     4'h4, 32'd0,          4'h0, 32'h2000_0000);
        add(OP_EOF,    4'h0, 32'd0,          4'h0, 32'd0);
        add(OP_BASE,   4'h0, 32'd0,          4'h0, 32'h2000_0000);
        add(OP_IRQNOW, 4'h0, 32'd0,          4'h0, 32'd0);
        add(OP_IRQ,    4'h0, 32'd0,          4'h0, 32'd1);
        add(OP_RD,     4'h4, 32'd0,          4'h0, 32'h0010_8078);
        add(OP_RD,     4'h0, 32'd0,          4'h0, 32'h0000_0002);
        add(OP_RD,     4'hC, 32'd0,          4'h0, 32'h0001_0001);
        add(OP_WR,     4'hC, 32'h0000_0001,  4'h1, 32'd0);
        add(OP_IRQ,    4'h0, 32'd0,          4'h0, 32'd0);
        add(OP_RD,     4'hC, 32'd0,          4'h0, 32'h0001_0000);
        add(OP_WR,     4'h4, 32'hAABB_CCDF,  4'h1, 32'd0);
        add(OP_RD,     4'h4, 32'd0,          4'h0, 32'h0010_80DC);
        add(OP_WR,     4'h8, 32'h1234_5678,  4'hF, 32'd0);
        add(OP_RD,     4'h8, 32'd0,          4'h0, 32'h2000_0000);
        add(OP_WR,     4'h0, 32'h0000_0003,  4'hE, 32'd0);
        add(OP_RD,     4'h0, 32'd0,          4'h0, 32'h0000_0002);
        add(OP_EOF,    4'h0, 32'd0,          4'h0, 32'd0);
        add(OP_BASE,   4'h0, 32'd0,          4'h0, 32'h2000_0000);
        add(OP_RD,     4'hC, 32'd0,          4'h0, 32'h0002_0000);

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_RD: begin
                    axi_read(tbl[i].addr, 0, rd);
                    chk($sformatf("vec%0d_read", i), rd, tbl[i].exp);
                end
                OP_WR:     axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 1'b0, 0);
                OP_EOF:    pulse_eof();
                OP_BASE:   chk($sformatf("vec%0d_base", i), base_addr, tbl[i].exp);
                OP_IRQ: begin
                    @(posedge clk); #1;
                    chk($sformatf("vec%0d_irq", i), swap_irq, tbl[i].exp);
                end
                default:   chk($sformatf("vec%0d_irqnow", i), swap_irq, tbl[i].exp);
            endcase
        end

        // SWAP_REQ on the end_of_frame edge: no swap now, swap on the next frame.
        axi_write(4'h0, 32'h0000_0003, 4'h1, 1'b1, 0);
        chk("swapreq_eof_base", base_addr, 32'h2000_0000);
        axi_read(4'h0, 0, rd);
        chk("swapreq_eof_pending", rd, 32'h0000_0003);
        pulse_eof();
        chk("swapreq_next_base", base_addr, 32'h0010_80DC);

        // IRQ clear racing a swap: the set wins.
        axi_write(4'hC, 32'h0000_0001, 4'h1, 1'b0, 0);
        axi_write(4'h0, 32'h0000_0003, 4'h1, 1'b0, 0);
        axi_write(4'hC, 32'h0000_0001, 4'h1, 1'b1, 0);
        axi_read(4'hC, 0, rd);
        chk("w1c_vs_set", rd[0], 1'b1);
        chk("w1c_vs_set_base", base_addr, 32'h2000_0000);

        // BACK_ADDR write racing a swap is dropped.
        axi_write(4'h0, 32'h0000_0003, 4'h1, 1'b0, 0);
        axi_write(4'h4, 32'h5555_5554, 4'hF, 1'b1, 0);
        chk("backwr_vs_swap_base", base_addr, 32'h0010_80DC);
        axi_read(4'h4, 0, rd);
        chk("backwr_vs_swap_back", rd, 32'h2000_0000);

        // Back-pressure on B and R channels.
        axi_write(4'h4, 32'h0000_1230, 4'hF, 1'b0, 5);
        axi_read(4'h4, 5, rd);
        chk("stall_read_data", rd, 32'h0000_1230);

        // Frame counter wrap.
        c0 = m_cnt;
        eof = 1'b1;
        repeat (65535) begin
            @(posedge clk);
            model_step(1'b0, 4'h0, 32'd0, 4'h0, 1'b1);
        end
        #1 eof = 1'b0;
        axi_read(4'hC, 0, rd);
        chk("cnt_before_wrap", rd, m_read(4'hC));
        pulse_eof();
        axi_read(4'hC, 0, rd);
        chk("cnt_wrapped", rd[31:16], {16'd0, c0});

        // Reset with a swap pending discards it.
        axi_write(4'h4, 32'h4000_0000, 4'hF, 1'b0, 0);
        axi_write(4'h0, 32'h0000_0001, 4'h1, 1'b0, 0);
        rst_n = 1'b0;
        #1 chk("async_rst_base", base_addr, 32'h0010_8078);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        pulse_eof();
        chk("rst_no_swap", base_addr, 32'h0010_8078);
        axi_read(4'hC, 0, rd);
        chk("rst_status", rd, 32'h0001_0000);
        axi_read(4'h0, 0, rd);
        chk("rst_ctrl", rd, 32'h0000_0000);

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            int op;
            logic [3:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 3);
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            case (op)
                0: begin
                    axi_write(a, d, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 0);
                    chk("rnd_base_after_wr", base_addr, m_base);
                end
                1: begin
                    axi_read(a, 0, rd);
                    chk($sformatf("rnd_read_%h", a), rd, m_read(a));
                end
                2: pulse_eof();
                default: begin
                    @(posedge clk); #1;
                    chk("rnd_irq", swap_irq, m_flag & m_en);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
